// File: rtl/prog_loader_if.sv
// Host-side word stream into the program loader: valid/ready handshake with a
// 32-bit instruction word and an end-of-program marker.
interface prog_loader_if;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;

    modport master (output host_valid, output host_data, output host_last, input host_ready);
    modport slave  (input host_valid, input host_data, input host_last, output host_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: streams host words into the CPU instruction memory, holds the CPU
// in reset while loading, then releases it. Optional macro: LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int BOOT_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      host,
    output logic              imw,
    output logic [31:0]       itw,
    output logic [AW-1:0]     iaddr,
    output logic              cnt,
    output logic              cpu_rst,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW:0]       words_loaded
);

    localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C       = (AW+1)'(32'd1);
    localparam logic [7:0]  HOLD_INIT_C = 8'(BOOT_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t          state_r;
    logic            host_ready_r;
    logic            imw_r;
    logic [31:0]     itw_r;
    logic [AW-1:0]   iaddr_r;
    logic [AW:0]     ptr_r;
    logic [7:0]      hold_cnt_r;
    logic            cpu_rst_r;
    logic            cpu_enable_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            hs_s;
    logic            full_s;
    logic [AW:0]     ptr_nxt_s;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     sum_r;
    logic            csum_ok_s;
`endif

    // Handshake detect and pointer look-ahead
    always_comb begin
        hs_s      = 1'b0;
        ptr_nxt_s = ptr_r + ONE_C;
        full_s    = 1'b0;
        if (state_r == ST_LOAD) begin
            hs_s = host.host_valid & host_ready_r;
        end else begin
            hs_s = 1'b0;
        end
        // The write about to issue is the last slot in memory
        full_s = (ptr_nxt_s >= DEPTH_C);
`ifdef LOADER_CHECKSUM_EN
        csum_ok_s = (sum_r == host.host_data);
`endif
    end

    // Loader state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            host_ready_r <= 1'b0;
            imw_r        <= 1'b0;
            itw_r        <= 32'h0000_0000;
            iaddr_r      <= '0;
            ptr_r        <= '0;
            hold_cnt_r   <= 8'd0;
            cpu_rst_r    <= 1'b1;
            cpu_enable_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_r        <= 32'h0000_0000;
`endif
        end else begin
            imw_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (start) begin
                        state_r      <= ST_LOAD;
                        ptr_r        <= '0;
                        host_ready_r <= 1'b1;
                        cpu_rst_r    <= 1'b1;
                        cpu_enable_r <= 1'b0;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_r        <= 32'h0000_0000;
`endif
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
`ifdef LOADER_CHECKSUM_EN
                        if (host.host_last) begin
                            // Checksum word: compared, never written
                            host_ready_r <= 1'b0;
                            if (csum_ok_s) begin
                                state_r    <= ST_HOLD;
                                hold_cnt_r <= HOLD_INIT_C;
                            end else begin
                                state_r <= ST_ERROR;
                                err_r   <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            imw_r   <= 1'b1;
                            itw_r   <= host.host_data;
                            iaddr_r <= ptr_r[AW-1:0];
                            ptr_r   <= ptr_nxt_s;
                            sum_r   <= sum_r + host.host_data;
                            if (full_s) begin
                                host_ready_r <= 1'b0;
                                state_r      <= ST_ERROR;
                                err_r        <= 1'b1;
                                busy_r       <= 1'b0;
                            end
                        end
`else
                        imw_r   <= 1'b1;
                        itw_r   <= host.host_data;
                        iaddr_r <= ptr_r[AW-1:0];
                        ptr_r   <= ptr_nxt_s;
                        if (host.host_last) begin
                            host_ready_r <= 1'b0;
                            state_r      <= ST_HOLD;
                            hold_cnt_r   <= HOLD_INIT_C;
                        end else if (full_s) begin
                            host_ready_r <= 1'b0;
                            state_r      <= ST_ERROR;
                            err_r        <= 1'b1;
                            busy_r       <= 1'b0;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == 8'd0) begin
                        state_r      <= ST_RUN;
                        cpu_rst_r    <= 1'b0;
                        cpu_enable_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.host_ready = host_ready_r;
    assign imw             = imw_r;
    assign cnt             = imw_r;
    assign itw             = itw_r;
    assign iaddr           = iaddr_r;
    assign cpu_rst         = cpu_rst_r;
    assign cpu_enable      = cpu_enable_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign words_loaded    = ptr_r;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the CPU core.
- Accepts a stream of 32-bit instruction words from a host port (valid/ready) and writes them sequentially into the CPU instruction memory write port (ins_mem_write / instruction_to_write / counter strobe).
- Holds the CPU in reset with enable low while loading, then releases it after a programmable hold time.
- One instance per CPU in the network.

Parameters:
- DEPTH, 64, instruction memory depth in words; the load limit.
- AW, 6, address width; must satisfy 2**AW >= DEPTH.
- BOOT_HOLD, 4, cycles cpu_rst stays high after the final write before release; range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, RUN and ERROR.
- host_valid  in  1  host word valid.
- host_data  in  32  instruction word.
- host_last  in  1  marks the final word of the program.
- host_ready  out  1  loader can accept a word.
- imw  out  1  instruction-memory write strobe (CPU ins_mem_write).
- itw  out  32  instruction to write (CPU instruction_to_write).
- iaddr  out  AW  write address.
- cnt  out  1  address-advance pulse (CPU counter input); equal to imw.
- cpu_rst  out  1  reset to the CPU.
- cpu_enable  out  1  enable to the CPU.
- busy  out  1  high in LOAD and HOLD.
- done  out  1  high in RUN.
- err  out  1  high in ERROR.
- words_loaded  out  AW+1  number of words written in the current or last load.

Behaviour:
- Reset: state=IDLE, host_ready=0, imw=cnt=0, itw=0, iaddr=0, cpu_rst=1, cpu_enable=0, busy=done=err=0, words_loaded=0. Reset dominates every other input, including mid-load; any partially loaded program is abandoned.
- IDLE:
  - cpu_rst=1, cpu_enable=0.
  - On start: go to LOAD, clear the write pointer and words_loaded.
- LOAD:
  - host_ready=1 while pointer < DEPTH.
  - Handshake occurs when host_valid & host_ready.
  - One cycle after a handshake: imw=cnt=1 for exactly one cycle, itw=host_data, iaddr=pointer; the pointer and words_loaded then increment. Write latency is 1 cycle.
  - Back-to-back handshakes give one write per cycle with no bubbles.
  - host_valid low: no write; itw and iaddr hold their previous values.
- LOAD exit conditions:
  - Handshake with host_last=1: host_ready drops in the next cycle, the last write issues, then go to HOLD.
  - Pointer reaches DEPTH without host_last: host_ready=0, go to ERROR, err=1. No write at address DEPTH or beyond; iaddr never wraps.
  - A handshake with host_last=1 on word DEPTH is legal and goes to HOLD, not ERROR.
- HOLD:
  - cpu_rst=1, cpu_enable=0, host_ready=0.
  - Count BOOT_HOLD cycles, then go to RUN.
- RUN:
  - cpu_rst=0, cpu_enable=1, done=1.
  - start: go to LOAD. cpu_rst=1 and cpu_enable=0 in the same cycle the state changes. done clears.
- ERROR:
  - cpu_rst=1, cpu_enable=0, err=1.
  - Left only via start (go to LOAD, err clears) or rst.
- start while in LOAD or HOLD is ignored.
- host_last arriving without host_valid is ignored.
- Zero-length load is not possible: the first accepted word is always written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - The word accepted with host_last is a checksum and is not written to memory.
  - The loader keeps a 32-bit wrapping sum of all written words.
  - Checksum equals the sum: go to HOLD as normal.
  - Checksum differs: go to ERROR with err=1.
  - words_loaded excludes the checksum word.
- When undefined: no accumulator; the host_last word is an ordinary instruction.

Test Plan:
- Reset: rst=1 for 3 cycles -> cpu_rst=1, cpu_enable=0, host_ready=0, imw=0, words_loaded=0.
- Normal load:
  - Stimulus: start, then 5 back-to-back words 0x11..0x15, last on 0x15.
  - Response: imw high for 5 consecutive cycles, iaddr 0..4, itw 0x11..0x15, words_loaded=5.
  - cpu_enable rises exactly BOOT_HOLD=4 cycles after the last imw; done=1.
- Stalled host: host_valid toggled 1,0,1,0 -> imw pulses only one cycle after each handshake; iaddr advances by 1 per write only.
- Overflow with DEPTH=4: send 5 words, none with last.
  - 4 writes at addresses 0..3, host_ready low after the 4th handshake.
  - err=1, CPU held in reset; a later start clears err and restarts at iaddr 0.
- Reload and reset mid-load:
  - start in RUN -> cpu_rst=1 the same cycle, new load begins at iaddr 0.
  - rst asserted after 2 of 5 words -> all outputs return to reset values.
- LOADER_CHECKSUM_EN:
  - Words 1,2,3 then checksum 6 with last -> 3 writes, RUN reached.
  - Checksum 7 -> ERROR, err=1, cpu_enable stays 0.
